ntt_agu: RTL and testbench

- Parametrised NTT/INTT butterfly address and twiddle-index generator. Replaces the fixed per-address twiddle/address ROM used by the current NTT datapath.
- On start, walks every layer of a Cooley-Tukey forward NTT or Gentleman-Sande inverse NTT. Each beat emits LANES butterfly address pairs plus one shared twiddle index over a valid/ready handshake.
- Sits between the NTT controller and the coefficient RAM / zeta ROM. Supports Kyber (N=256, 7 layers) and larger ring sizes.

---
 rtl/ntt_pkg.sv | 30 +++
 rtl/ntt_agu_lane.sv | 32 +++
 rtl/ntt_agu.sv | 163 ++++++++++++++++
 tb/tb_ntt_agu.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT address/twiddle generator.
// Kyber ring constants, the transform mode and the AGU sequencing states.
package ntt_pkg;

  localparam int unsigned KYBER_N  = 256;
  localparam int unsigned KYBER_Q  = 3329;
  localparam int unsigned KYBER_NL = 7;

  typedef enum logic {
    FWD = 1'b0,
    INV = 1'b1
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Returns log2(len): forward spans shrink from N/2, inverse spans grow from 2^min_log_len.
  function automatic int unsigned ntt_log_len(input int unsigned log_n,
                                              input int unsigned min_log_len,
                                              input int unsigned layer,
                                              input mode_e       mode);
    if (mode == INV) return min_log_len + layer;
    return log_n - 1 - layer;
  endfunction

endpackage

// File: rtl/ntt_agu_lane.sv
// One butterfly lane: maps (beat, lane, log_len) to its address pair and group index.
// Purely combinational; the parent registers the results.
module ntt_agu_lane
  import ntt_pkg::*;
#(
  parameter int unsigned LOG_N = 8,
  parameter int unsigned LANES = 2,
  parameter int unsigned LLW   = 4
) (
  input  logic [LOG_N-2:0] beat_i,
  input  logic [LOG_N-2:0] lane_i,
  input  logic [LLW-1:0]   log_len_i,
  output logic [LOG_N-1:0] addr_a_o,
  output logic [LOG_N-1:0] addr_b_o,
  output logic [LOG_N-2:0] g_o
);

  logic [LOG_N-2:0] idx;
  logic [LOG_N-2:0] mask;
  logic [LOG_N-1:0] len;

  always_comb begin
    idx  = beat_i * (LOG_N-1)'(LANES) + lane_i;
    len  = LOG_N'(1) << log_len_i;
    // For len = N/2 the low bits are zero and the mask wraps to all ones, which is what j needs.
    mask = len[LOG_N-2:0] - (LOG_N-1)'(1);
    g_o  = idx >> log_len_i;
    addr_a_o = ({1'b0, g_o} << (log_len_i + LLW'(1))) | {1'b0, idx & mask};
    addr_b_o = addr_a_o + len;
  end

endmodule

// File: rtl/ntt_agu.sv
// NTT/INTT butterfly address and twiddle-index generator, LANES butterflies per beat.
// state  | meaning
// IDLE   | waiting for start
// RUN    | issuing beats of the current layer
// GAP    | drain cycles between layers, out_valid low
// DONE   | one-cycle done pulse
module ntt_agu
  import ntt_pkg::*;
#(
  parameter  int unsigned LOG_N       = 8,
  parameter  int unsigned LANES       = 2,
  parameter  int unsigned MIN_LOG_LEN = 1,
  parameter  int unsigned LAYER_GAP   = 0,
  localparam int unsigned NL          = LOG_N - MIN_LOG_LEN,
  localparam int unsigned LW          = (NL > 1) ? $clog2(NL) : 1
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   start,
  input  logic                   inverse,
  output logic                   busy,
  output logic                   done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*LOG_N-1:0] out_addr_a,
  output logic [LANES*LOG_N-1:0] out_addr_b,
  output logic [LOG_N-2:0]       out_zeta_idx,
  output logic [LW-1:0]          out_layer,
  output logic                   out_layer_last,
  output logic                   out_last
);

  localparam int unsigned LLW   = $clog2(LOG_N) + 1;
  localparam int unsigned BEATS = (1 << LOG_N) / (2 * LANES);
  localparam logic [LOG_N-2:0] B_LAST   = (LOG_N-1)'(BEATS - 1);
  localparam logic [LOG_N-2:0] Z_ONE    = (LOG_N-1)'(1);
  localparam logic [3:0]       GAP_LOAD = (LAYER_GAP > 0) ? 4'(LAYER_GAP - 1) : 4'd0;

  state_e           state_q;
  mode_e            mode_q, mode_n;
  logic [LW-1:0]    layer_q, layer_n;
  logic [LOG_N-2:0] beat_q, beat_n;
  logic [3:0]       gap_q;

  logic [LLW-1:0]         log_len_n;
  logic [LANES*LOG_N-1:0] addr_a_n, addr_b_n;
  logic [LOG_N-2:0]       g_arr [LANES];
  logic [LOG_N-2:0]       g_n, zeta_n;
  logic                   layer_last_n, last_n, adv;

  // Outputs are registered from the position of the beat that will be presented next.
  always_comb begin
    mode_n  = mode_q;
    layer_n = layer_q;
    beat_n  = beat_q;
    if (state_q == S_IDLE) begin
      mode_n  = inverse ? INV : FWD;
      layer_n = '0;
      beat_n  = '0;
    end else if (beat_q == B_LAST) begin
      layer_n = layer_q + LW'(1);
      beat_n  = '0;
    end else begin
      beat_n = beat_q + (LOG_N-1)'(1);
    end
    log_len_n    = LLW'(ntt_log_len(LOG_N, MIN_LOG_LEN, 32'(layer_n), mode_n));
    layer_last_n = (beat_n == B_LAST);
    last_n       = layer_last_n && (layer_n == LW'(NL - 1));
    adv = ((state_q == S_IDLE) && start) ||
          ((state_q == S_RUN) && out_valid && out_ready && !out_last);
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ntt_agu_lane #(
      .LOG_N(LOG_N),
      .LANES(LANES),
      .LLW  (LLW)
    ) u_lane (
      .beat_i   (beat_n),
      .lane_i   ((LOG_N-1)'(k)),
      .log_len_i(log_len_n),
      .addr_a_o (addr_a_n[k*LOG_N +: LOG_N]),
      .addr_b_o (addr_b_n[k*LOG_N +: LOG_N]),
      .g_o      (g_arr[k])
    );
  end

  // Every lane of a beat sits in the same group, so the OR equals lane 0's g.
  always_comb begin
    g_n = '0;
    for (int k = 0; k < LANES; k++) g_n = g_n | g_arr[k];
    if (mode_n == INV) zeta_n = (Z_ONE << (LLW'(LOG_N) - log_len_n)) - Z_ONE - g_n;
    else               zeta_n = (Z_ONE << layer_n) + g_n;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q        <= S_IDLE;
      mode_q         <= FWD;
      layer_q        <= '0;
      beat_q         <= '0;
      gap_q          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      out_valid      <= 1'b0;
      out_addr_a     <= '0;
      out_addr_b     <= '0;
      out_zeta_idx   <= '0;
      out_layer      <= '0;
      out_layer_last <= 1'b0;
      out_last       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_RUN;
            busy      <= 1'b1;
            out_valid <= 1'b1;
          end
        end
        S_RUN: begin
          if (out_valid && out_ready) begin
            if (out_last) begin
              state_q   <= S_DONE;
              busy      <= 1'b0;
              done      <= 1'b1;
              out_valid <= 1'b0;
            end else if (out_layer_last && (LAYER_GAP > 0)) begin
              state_q   <= S_GAP;
              gap_q     <= GAP_LOAD;
              out_valid <= 1'b0;
            end
          end
        end
        S_GAP: begin
          if (gap_q == 4'd0) begin
            state_q   <= S_RUN;
            out_valid <= 1'b1;
          end else begin
            gap_q <= gap_q - 4'd1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done    <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
      if (adv) begin
        mode_q         <= mode_n;
        layer_q        <= layer_n;
        beat_q         <= beat_n;
        out_addr_a     <= addr_a_n;
        out_addr_b     <= addr_b_n;
        out_zeta_idx   <= zeta_n;
        out_layer      <= layer_n;
        out_layer_last <= layer_last_n;
        out_last       <= last_n;
      end
    end
  end

endmodule

// File: tb/tb_ntt_agu.sv
// Bench for ntt_agu: Kyber-size forward/inverse walks against an arithmetic reference,
// random backpressure and start pokes, layer gaps, and mid-transform reset.
module tb_ntt_agu;

  logic clk = 1'b0;
  logic srst = 1'b1;
  logic inverse = 1'b0;
  logic start0 = 1'b0, start1 = 1'b0;
  logic ready0 = 1'b0, ready1 = 1'b0;

  logic        busy0, done0, valid0, ll0, last0;
  logic        busy1, done1, valid1, ll1, last1;
  logic [15:0] a0v, b0v, a1v, b1v;
  logic [6:0]  z0, z1;
  logic [2:0]  l0, l1;

  int errors = 0;
  int checks = 0;
  bit sel = 1'b0;

  logic        obs_valid, obs_busy, obs_done;
  logic [43:0] obs_vec;

  always #5 clk = ~clk;

  ntt_agu #(.LOG_N(8), .LANES(2), .MIN_LOG_LEN(1), .LAYER_GAP(0)) u_dut (
    .clk(clk), .srst(srst), .start(start0), .inverse(inverse),
    .busy(busy0), .done(done0), .out_valid(valid0), .out_ready(ready0),
    .out_addr_a(a0v), .out_addr_b(b0v), .out_zeta_idx(z0), .out_layer(l0),
    .out_layer_last(ll0), .out_last(last0)
  );

  ntt_agu #(.LOG_N(8), .LANES(2), .MIN_LOG_LEN(1), .LAYER_GAP(3)) u_dut_gap (
    .clk(clk), .srst(srst), .start(start1), .inverse(inverse),
    .busy(busy1), .done(done1), .out_valid(valid1), .out_ready(ready1),
    .out_addr_a(a1v), .out_addr_b(b1v), .out_zeta_idx(z1), .out_layer(l1),
    .out_layer_last(ll1), .out_last(last1)
  );

  always_comb begin
    obs_valid = sel ? valid1 : valid0;
    obs_busy  = sel ? busy1  : busy0;
    obs_done  = sel ? done1  : done0;
    obs_vec   = sel ? {z1, l1, ll1, last1, a1v, b1v} : {z0, l0, ll0, last0, a0v, b0v};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [43:0] pv(input int z, input int L, input bit ll, input bit last,
                                     input int a0, input int a1, input int b0, input int b1);
    return {z[6:0], L[2:0], ll, last, a1[7:0], a0[7:0], b1[7:0], b0[7:0]};
  endfunction

  // Reference: beat n of a 448-beat walk, straight from the len/group/offset arithmetic.
  function automatic logic [43:0] model_beat(input bit inv, input int n);
    int L, b, len, i, g, j, g0, z;
    int a [2];
    int bb [2];
    L = n / 64;
    b = n % 64;
    len = inv ? (1 << (1 + L)) : (256 >> (L + 1));
    g0 = 0;
    for (int k = 0; k < 2; k++) begin
      i = b * 2 + k;
      g = i / len;
      j = i % len;
      a[k] = g * 2 * len + j;
      bb[k] = a[k] + len;
      if (k == 0) g0 = g;
    end
    z = inv ? (2 * (256 / (2 * len)) - 1 - g0) : ((1 << L) + g0);
    return pv(z, L, b == 63, (b == 63) && (L == 6), a[0], a[1], bb[0], bb[1]);
  endfunction

  // Hand-worked beats; MSB flags whether (inv, n) has an entry.
  function automatic logic [44:0] plan(input bit inv, input int n);
    if (!inv && n == 0)   return {1'b1, pv(1,   0, 0, 0, 0,   1,   128, 129)};
    if (!inv && n == 63)  return {1'b1, pv(1,   0, 1, 0, 126, 127, 254, 255)};
    if (!inv && n == 96)  return {1'b1, pv(3,   1, 0, 0, 128, 129, 192, 193)};
    if (!inv && n == 384) return {1'b1, pv(64,  6, 0, 0, 0,   1,   2,   3)};
    if (!inv && n == 447) return {1'b1, pv(127, 6, 1, 1, 252, 253, 254, 255)};
    if (inv && n == 0)    return {1'b1, pv(127, 0, 0, 0, 0,   1,   2,   3)};
    if (inv && n == 64)   return {1'b1, pv(63,  1, 0, 0, 0,   1,   4,   5)};
    if (inv && n == 447)  return {1'b1, pv(1,   6, 1, 1, 126, 127, 254, 255)};
    return '0;
  endfunction

  task automatic drive_start(input bit v);
    if (sel) start1 = v; else start0 = v;
  endtask

  task automatic drive_ready(input bit v);
    if (sel) ready1 = v; else ready0 = v;
  endtask

  task automatic run_xfm(input bit s, input bit inv, input int ready_pct, input bit poke,
                         input int abort_at);
    int n, cyc, gap_cnt;
    bit in_gap, rdy, aborted;
    logic [44:0] p;
    n = 0; cyc = 0; gap_cnt = 0; in_gap = 1'b0; aborted = 1'b0;
    sel = s;
    @(negedge clk);
    inverse = inv;
    drive_ready(1'b0);
    drive_start(1'b1);
    @(negedge clk);
    drive_start(1'b0);
    chk("busy_after_start", obs_busy, 1);
    chk("valid_after_start", obs_valid, 1);
    while (n < 448 && cyc < 4000 && !aborted) begin
      if (obs_valid) begin
        if (in_gap) begin
          chk("gap_len", gap_cnt, s ? 3 : 0);
          in_gap = 1'b0;
        end
        chk("beat", obs_vec, model_beat(inv, n));
        p = plan(inv, n);
        if (p[44]) chk("plan_beat", obs_vec, p[43:0]);
        if (n == abort_at) begin
          srst = 1'b1;
          aborted = 1'b1;
        end else begin
          rdy = ($urandom_range(99) < ready_pct);
          drive_ready(rdy);
          if (rdy) begin
            if (obs_vec[33] && !obs_vec[32]) begin
              in_gap = 1'b1;
              gap_cnt = 0;
            end
            n++;
          end
        end
      end else if (in_gap) begin
        gap_cnt++;
        chk("busy_in_gap", obs_busy, 1);
      end else begin
        chk("valid_in_run", obs_valid, 1);
      end
      chk("no_early_done", obs_done, 0);
      if (poke) begin
        drive_start($urandom_range(3) == 0);
        inverse = $urandom_range(1);
      end
      @(negedge clk);
      cyc++;
    end
    drive_start(1'b0);
    inverse = inv;
    if (aborted) begin
      chk("abort_busy", obs_busy, 0);
      chk("abort_valid", obs_valid, 0);
      chk("abort_done", obs_done, 0);
      chk("abort_data", obs_vec, 0);
      srst = 1'b0;
      repeat (3) begin
        @(negedge clk);
        chk("abort_no_done", obs_done, 0);
        chk("abort_idle_valid", obs_valid, 0);
      end
    end else begin
      chk("beat_count", n, 448);
      chk("done_pulse", obs_done, 1);
      chk("done_valid_low", obs_valid, 0);
      chk("done_busy_low", obs_busy, 0);
      @(negedge clk);
      chk("done_clear", obs_done, 0);
      chk("idle_busy", obs_busy, 0);
      chk("idle_valid", obs_valid, 0);
    end
    drive_ready(1'b0);
  endtask

  initial begin
    srst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_valid", valid0, 0);
    chk("rst_addr_a", a0v, 0);
    chk("rst_addr_b", b0v, 0);
    chk("rst_zeta", z0, 0);
    chk("rst_layer", l0, 0);
    chk("rst_flags", {ll0, last0}, 0);
    chk("rst_gap_valid", valid1, 0);
    chk("rst_gap_busy", busy1, 0);
    srst = 1'b0;
    @(negedge clk);
    chk("idle_no_valid", valid0, 0);

    run_xfm(1'b0, 1'b0, 100, 1'b0, -1);
    run_xfm(1'b0, 1'b1, 100, 1'b0, -1);
    run_xfm(1'b0, 1'b0, 50,  1'b1, -1);
    run_xfm(1'b0, 1'b1, 50,  1'b1, -1);
    run_xfm(1'b1, 1'b0, 100, 1'b0, -1);
    run_xfm(1'b1, 1'b1, 50,  1'b1, -1);
    run_xfm(1'b0, 1'b0, 50,  1'b0, 100);
    run_xfm(1'b0, 1'b0, 100, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
